// File: rtl/shift_lfsr_reg.sv
// rtl/shift_lfsr_reg.sv - multi-mode register: load, shift, rotate, LFSR step, up/down count
// Optional: define LFSR_LOCKUP_RECOVER_EN to step an all-zero LFSR state to 1.
module shift_lfsr_reg #(
   parameter int               WIDTH     = 3,
   parameter logic [WIDTH-1:0] TAPS      = 3'b110,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] R,
   input  logic             L,
   input  logic [2:0]       mode,
   input  logic             sin,
   output logic [WIDTH-1:0] Qout,
   output logic             sout,
   output logic             wrap
);

   localparam logic [2:0] MODE_HOLD   = 3'b000;
   localparam logic [2:0] MODE_SHL    = 3'b001;
   localparam logic [2:0] MODE_SHR    = 3'b010;
   localparam logic [2:0] MODE_ROL    = 3'b011;
   localparam logic [2:0] MODE_ROR    = 3'b100;
   localparam logic [2:0] MODE_LFSR   = 3'b101;
   localparam logic [2:0] MODE_UP     = 3'b110;
   localparam logic [2:0] MODE_DOWN   = 3'b111;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] next_q;
   logic             next_wrap;
   logic [WIDTH-1:0] lfsr_next;
   logic             lfsr_fb;
   logic             q_all_ones;
   logic             q_zero;

   assign q_all_ones = &Qout;
   assign q_zero     = ~|Qout;
   assign lfsr_fb    = ^(Qout & TAPS);

`ifdef LFSR_LOCKUP_RECOVER_EN
   // Kick the all-zero state out of lockup; the period check still uses seed.
   assign lfsr_next = q_zero ? ONE : {Qout[WIDTH-2:0], lfsr_fb};
`else
   assign lfsr_next = {Qout[WIDTH-2:0], lfsr_fb};
`endif

   always_comb begin
      next_q    = Qout;
      next_wrap = 1'b0;
      case (mode)
         MODE_HOLD: next_q = Qout;
         MODE_SHL:  next_q = {Qout[WIDTH-2:0], sin};
         MODE_SHR:  next_q = {sin, Qout[WIDTH-1:1]};
         MODE_ROL:  next_q = {Qout[WIDTH-2:0], Qout[WIDTH-1]};
         MODE_ROR:  next_q = {Qout[0], Qout[WIDTH-1:1]};
         MODE_LFSR: begin
            next_q    = lfsr_next;
            next_wrap = (lfsr_next == seed);
         end
         MODE_UP: begin
            next_q    = Qout + ONE;
            next_wrap = q_all_ones;
         end
         MODE_DOWN: begin
            next_q    = Qout - ONE;
            next_wrap = q_zero;
         end
         default: begin
            next_q    = Qout;
            next_wrap = 1'b0;
         end
      endcase
   end

   // sout is the bit the coming edge moves out of the register.
   always_comb begin
      sout = 1'b0;
      case (mode)
         MODE_SHL, MODE_ROL: sout = Qout[WIDTH-1];
         MODE_SHR, MODE_ROR: sout = Qout[0];
         default:            sout = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Qout <= RESET_VAL;
         seed <= RESET_VAL;
         wrap <= 1'b0;
      end else if (L) begin
         Qout <= R;
         seed <= R;
         wrap <= 1'b0;
      end else begin
         Qout <= next_q;
         wrap <= next_wrap;
      end
   end

endmodule

// File: tb/tb_shift_lfsr_reg.sv
// tb/tb_shift_lfsr_reg.sv - scoreboard bench for shift_lfsr_reg at WIDTH 3 and WIDTH 8
module tb_shift_lfsr_reg;

   typedef struct packed {
      logic [31:0] q;
      logic        wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] r3;
   logic       l3;
   logic [2:0] mode3;
   logic       sin3;
   logic [2:0] q3;
   logic       sout3;
   logic       wrap3;
   logic [7:0] r8;
   logic       l8;
   logic [2:0] mode8;
   logic       sin8;
   logic [7:0] q8;
   logic       sout8;
   logic       wrap8;

   int checks   = 0;
   int failures = 0;

   exp_t sb3[$];
   exp_t sb8[$];
   logic [31:0] m3_q, m3_seed, m8_q, m8_seed;

   always #5 clk = ~clk;

   shift_lfsr_reg #(.WIDTH(3), .TAPS(3'b110), .RESET_VAL(3'b000)) dut3 (
      .clk(clk), .rst(rst), .R(r3), .L(l3), .mode(mode3), .sin(sin3),
      .Qout(q3), .sout(sout3), .wrap(wrap3)
   );

   shift_lfsr_reg #(.WIDTH(8), .TAPS(8'hB8), .RESET_VAL(8'h00)) dut8 (
      .clk(clk), .rst(rst), .R(r8), .L(l8), .mode(mode8), .sin(sin8),
      .Qout(q8), .sout(sout8), .wrap(wrap8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input int w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   // Returns {wrap, next_q}.
   function automatic logic [32:0] model_next(input logic [31:0] q, input logic [31:0] seed,
                                              input logic [31:0] r, input logic [31:0] taps,
                                              input logic l, input logic s,
                                              input logic [2:0] m, input int w);
      logic [31:0] mk, nq, sb;
      logic        wr, fb;
      mk = mask_of(w);
      nq = q;
      wr = 1'b0;
      sb = {31'd0, s} << (w - 1);
      if (l) return {1'b0, r & mk};
      case (m)
         3'b001: nq = ((q << 1) | {31'd0, s}) & mk;
         3'b010: nq = (q >> 1) | sb;
         3'b011: nq = ((q << 1) | {31'd0, q[w-1]}) & mk;
         3'b100: nq = (q >> 1) | ({31'd0, q[0]} << (w - 1));
         3'b101: begin
            fb = ^(q & taps);
            nq = ((q << 1) | {31'd0, fb}) & mk;
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (q == 32'd0) nq = 32'd1;
`endif
            wr = (nq == seed);
         end
         3'b110: begin
            nq = (q + 32'd1) & mk;
            wr = (q == mk);
         end
         3'b111: begin
            nq = (q - 32'd1) & mk;
            wr = (q == 32'd0);
         end
         default: nq = q;
      endcase
      return {wr, nq};
   endfunction

   function automatic logic model_sout(input logic [31:0] q, input logic [2:0] m, input int w);
      if (m == 3'b001 || m == 3'b011) return q[w-1];
      if (m == 3'b010 || m == 3'b100) return q[0];
      return 1'b0;
   endfunction

   task automatic drive3(input logic l, input logic [2:0] r, input logic [2:0] m, input logic s);
      logic [32:0] res;
      exp_t        e;
      l3 = l; r3 = r; mode3 = m; sin3 = s;
      #1;
      check("sout3", {31'd0, sout3}, {31'd0, model_sout(m3_q, m, 3)});
      res = model_next(m3_q, m3_seed, {29'd0, r}, 32'h6, l, s, m, 3);
      m3_q = res[31:0];
      if (l) m3_seed = {29'd0, r};
      sb3.push_back('{q: res[31:0], wrap: res[32]});
      @(posedge clk);
      #1;
      e = sb3.pop_front();
      check("q3", {29'd0, q3}, e.q);
      check("wrap3", {31'd0, wrap3}, {31'd0, e.wrap});
   endtask

   task automatic drive8(input logic l, input logic [7:0] r, input logic [2:0] m, input logic s);
      logic [32:0] res;
      exp_t        e;
      l8 = l; r8 = r; mode8 = m; sin8 = s;
      #1;
      check("sout8", {31'd0, sout8}, {31'd0, model_sout(m8_q, m, 8)});
      res = model_next(m8_q, m8_seed, {24'd0, r}, 32'hB8, l, s, m, 8);
      m8_q = res[31:0];
      if (l) m8_seed = {24'd0, r};
      sb8.push_back('{q: res[31:0], wrap: res[32]});
      @(posedge clk);
      #1;
      e = sb8.pop_front();
      check("q8", {24'd0, q8}, e.q);
      check("wrap8", {31'd0, wrap8}, {31'd0, e.wrap});
   endtask

   task automatic model_reset();
      m3_q = 0; m3_seed = 0; m8_q = 0; m8_seed = 0;
   endtask

   initial begin
      logic [2:0] lfsr_seq [7];
      int         wraps;
      lfsr_seq = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
      rst = 1'b1;
      r3 = 0; l3 = 0; mode3 = 0; sin3 = 0;
      r8 = 0; l8 = 0; mode8 = 0; sin8 = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_q3", {29'd0, q3}, 32'd0);
      check("rst_wrap3", {31'd0, wrap3}, 32'd0);
      check("rst_q8", {24'd0, q8}, 32'd0);
      rst = 1'b0;
      drive3(0, 3'b000, 3'b000, 0);

      // Asynchronous reset mid-operation.
      drive3(1, 3'b101, 3'b000, 0);
      check("load_101", {29'd0, q3}, 32'd5);
      #3 rst = 1'b1;
      #1;
      check("async_rst_q3", {29'd0, q3}, 32'd0);
      check("async_rst_wrap3", {31'd0, wrap3}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      drive3(0, 3'b000, 3'b000, 0);
      check("post_rst_hold", {29'd0, q3}, 32'd0);

      // Reset clears a live wrap pulse without a clock edge.
      drive3(1, 3'b111, 3'b000, 0);
      drive3(0, 3'b000, 3'b110, 0);
      check("pre_rst_wrap", {31'd0, wrap3}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_wrap_clr", {31'd0, wrap3}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();

      // LFSR period from seed 001.
      drive3(1, 3'b001, 3'b000, 0);
      for (int i = 0; i < 7; i++) begin
         drive3(0, 3'b000, 3'b101, 0);
         check("lfsr_seq", {29'd0, q3}, {29'd0, lfsr_seq[i]});
         check("lfsr_wrap", {31'd0, wrap3}, (i == 6) ? 32'd1 : 32'd0);
      end

      // Counter wrap both directions.
      drive3(1, 3'b110, 3'b000, 0);
      drive3(0, 3'b000, 3'b110, 0);
      check("up_111", {28'd0, wrap3, q3}, 32'h7);
      drive3(0, 3'b000, 3'b110, 0);
      check("up_000", {28'd0, wrap3, q3}, 32'h8);
      drive3(0, 3'b000, 3'b111, 0);
      check("down_111", {28'd0, wrap3, q3}, 32'hF);
      drive3(0, 3'b000, 3'b111, 0);
      check("down_110", {28'd0, wrap3, q3}, 32'h6);

      // Shift and rotate.
      drive3(1, 3'b100, 3'b000, 0);
      l3 = 0; mode3 = 3'b001; sin3 = 1;
      #1;
      check("sout_pre_shl", {31'd0, sout3}, 32'd1);
      drive3(0, 3'b000, 3'b001, 1);
      check("shl_001", {29'd0, q3}, 32'd1);
      drive3(0, 3'b000, 3'b100, 0);
      check("ror_100", {29'd0, q3}, 32'd4);
      drive3(0, 3'b000, 3'b100, 0);
      check("ror_010", {29'd0, q3}, 32'd2);

      // Load priority and all-zero LFSR behaviour.
      drive3(1, 3'b011, 3'b101, 0);
      check("load_prio", {28'd0, wrap3, q3}, 32'h3);
      drive3(1, 3'b000, 3'b101, 0);
      drive3(0, 3'b000, 3'b101, 0);
`ifdef LFSR_LOCKUP_RECOVER_EN
      check("lfsr_zero", {28'd0, wrap3, q3}, 32'h1);
`else
      check("lfsr_zero", {28'd0, wrap3, q3}, 32'h8);
`endif

      for (int i = 0; i < 200; i++)
         drive3($urandom_range(0, 7) == 0, 3'($urandom), 3'($urandom), 1'($urandom));

      // WIDTH=8 maximal-length period.
      drive8(1, 8'h01, 3'b000, 0);
      wraps = 0;
      for (int i = 0; i < 255; i++) begin
         drive8(0, 8'h00, 3'b101, 0);
         if (wrap8) wraps++;
      end
      check("lfsr8_final", {24'd0, q8}, 32'h01);
      check("lfsr8_wraps", wraps, 32'd1);

      drive8(1, 8'hFF, 3'b000, 0);
      drive8(0, 8'h00, 3'b110, 0);
      check("up8_wrap", {23'd0, wrap8, q8}, 32'h100);

      for (int i = 0; i < 200; i++)
         drive8($urandom_range(0, 7) == 0, 8'($urandom), 3'($urandom), 1'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shift_lfsr_reg.md
Name: shift_lfsr_reg

Overview:
- Parametrised multi-mode register: parallel load, shift, rotate, LFSR step and up/down count.
- Generalises the 3-bit load/step register to WIDTH bits with selectable modes, serial I/O and a wrap/period flag.
- Used as the pattern/sequence generator in lab datapaths and benches.
- Single clock; all state is updated on the rising edge.

Parameters:
WIDTH, 3, register width in bits (legal range 2..32)
TAPS, 3'b110, Fibonacci feedback mask; bit i set means Qout[i] feeds the XOR. Default is x^3+x^2+1 (maximal, period 7).
RESET_VAL, 0, value loaded into Qout and seed on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
R  input  WIDTH  parallel load data
L  input  1  load enable; overrides mode
mode  input  3  operation select, used when L=0
sin  input  1  serial input for shift modes
Qout  output  WIDTH  register state (registered)
sout  output  1  serial output (combinational from Qout and mode)
wrap  output  1  registered one-cycle wrap/period pulse

Behaviour:
- Reset (async, rst=1): Qout=RESET_VAL, internal seed=RESET_VAL, wrap=0. Holds while rst is high. Deassertion mid-sequence restarts from RESET_VAL; no partial update occurs.
- Priority at the clock edge: rst > L > mode.
- L=1: Qout<=R, seed<=R, wrap<=0. mode is ignored.
- L=0, per mode:
  - 000 hold: Qout unchanged.
  - 001 shift left: Qout<={Qout[WIDTH-2:0],sin}.
  - 010 shift right: Qout<={sin,Qout[WIDTH-1:1]}.
  - 011 rotate left: Qout<={Qout[WIDTH-2:0],Qout[WIDTH-1]}.
  - 100 rotate right: Qout<={Qout[0],Qout[WIDTH-1:1]}.
  - 101 LFSR step: fb=^(Qout & TAPS); Qout<={Qout[WIDTH-2:0],fb}.
  - 110 count up: Qout<=Qout+1, modulo 2^WIDTH.
  - 111 count down: Qout<=Qout-1, modulo 2^WIDTH.
- Latency: every update appears on Qout one edge after the inputs are sampled. Inputs sample on the rising edge; the bench drives them away from the edge.
- wrap (registered, high for exactly one cycle after the causing edge):
  - mode 101 and next Qout == seed.
  - mode 110 and Qout was all-ones (now 0).
  - mode 111 and Qout was 0 (now all-ones).
  - Otherwise 0, including hold, shift, rotate and load.
- sout:
  - Qout[WIDTH-1] in modes 001 and 011.
  - Qout[0] in modes 010 and 100.
  - 0 in all other modes.
  - sout reflects the bit that the next edge shifts or rotates out.
- seed changes only on load or reset. The LFSR period check compares against the last loaded value.
- LFSR all-zero state: feedback is 0, so Qout stays 0 (lockup) unless the optional feature is enabled. wrap asserts every step while locked when seed==0.
- Mode changes take effect on the next edge; no pipeline state carries between modes.

Optional Feature:
- Macro: LFSR_LOCKUP_RECOVER_EN.
- Defined: in mode 101, if Qout==0 the step yields Qout<=1 (value 1) instead of 0. wrap then follows the normal next-value==seed rule.
- Not defined: all-zero LFSR lockup persists as described above.
- No other behaviour differs between the two builds.

Test Plan:
- Reset: rst=1 mid-operation with Qout=3'b101 -> Qout=000 and wrap=0 immediately, without waiting for a clock edge. After release with mode=000, Qout stays 000.
- LFSR period: load R=001, then mode=101 for 7 edges -> Qout sequence 010,101,011,111,110,100,001. wrap=1 only in the cycle after the 7th edge.
- Counter wrap: load 110, mode=110 -> 111, then 000 with wrap pulse. Switch to mode=111 -> 111 with wrap pulse, then 110 with wrap=0.
- Shift/rotate: load 100, mode=001 with sin=1 -> sout=1 before the edge, Qout=001 after. Then mode=100 -> 100, then 010.
- Load priority: L=1, R=011 with mode=101 -> Qout=011 and wrap=0. With R=000 then mode=101 -> Qout stays 000 (macro off) or becomes 001 (macro on).
- WIDTH=8, TAPS=8'hB8: load 8'h01, step 255 times -> Qout returns to 8'h01 and wrap pulses exactly once.
